// File: rtl/cycle_detector.sv
// rtl/cycle_detector.sv - attractor detector: first cycle of period 1..DEPTH in a state stream
// Optional post-lock monitor enabled by defining CYCLE_MONITOR_EN.
module cycle_detector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int PW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_val_chk,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x,
  output logic             cycle_chk,
  output logic [PW-1:0]    period,
  output logic [CNT_W-1:0] transient,
  output logic [CNT_W-1:0] steps,
  output logic             cycle_broken
);

  logic [WIDTH-1:0] hist [1:DEPTH];
  logic [DEPTH:1]   hv;
  logic             accept;
  logic             shift_en;
  logic             hit;
  logic [PW-1:0]    hit_k;

  assign accept = x_valid && !init_val_chk;

  // Scanning from the deepest entry down leaves the smallest matching k.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hv[k] && hist[k] == x) begin
        hit   = 1'b1;
        hit_k = PW'(k);
      end
    end
  end

`ifdef CYCLE_MONITOR_EN
  assign shift_en = accept;
`else
  assign shift_en = accept && !cycle_chk;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv <= '0;
      for (int k = 1; k <= DEPTH; k++) hist[k] <= '0;
    end else if (init_val_chk) begin
      hv <= '0;
    end else if (shift_en) begin
      hist[1] <= x;
      hv[1]   <= 1'b1;
      for (int k = 2; k <= DEPTH; k++) begin
        hist[k] <= hist[k-1];
        hv[k]   <= hv[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_chk <= 1'b0;
      period    <= '0;
      transient <= '0;
      steps     <= '0;
    end else if (init_val_chk) begin
      cycle_chk <= 1'b0;
      period    <= '0;
      transient <= '0;
      steps     <= '0;
    end else if (accept) begin
      if (!cycle_chk && hit) begin
        cycle_chk <= 1'b1;
        period    <= hit_k;
        // A saturated step count makes this value a lower bound only.
        transient <= steps - CNT_W'(hit_k);
      end
      if (steps != '1) steps <= steps + CNT_W'(1);
    end
  end

`ifdef CYCLE_MONITOR_EN
  logic [WIDTH-1:0] mon_val;

  always_comb begin
    mon_val = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (period == PW'(k)) mon_val = hist[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_broken <= 1'b0;
    end else if (init_val_chk) begin
      cycle_broken <= 1'b0;
    end else if (accept && cycle_chk && mon_val != x) begin
      cycle_broken <= 1'b1;
    end
  end
`else
  assign cycle_broken = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_detector.sv
// tb/tb_cycle_detector.sv - scoreboard bench for cycle_detector (honours CYCLE_MONITOR_EN)
module tb_cycle_detector;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;
  localparam int PW    = $clog2(DEPTH + 1);
`ifdef CYCLE_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             init_val_chk = 1'b0;
  logic             x_valid = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic             cycle_chk;
  logic [PW-1:0]    period;
  logic [CNT_W-1:0] transient;
  logic [CNT_W-1:0] steps;
  logic             cycle_broken;

  cycle_detector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .init_val_chk(init_val_chk), .x_valid(x_valid), .x(x),
    .cycle_chk(cycle_chk), .period(period), .transient(transient), .steps(steps),
    .cycle_broken(cycle_broken)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit cyc;
    int per;
    int tr;
    int st;
    bit br;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: full list of accepted samples since the last restart.
  logic [WIDTH-1:0] m_hist[$];
  bit m_cyc, m_br;
  int m_per, m_tr, m_st;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_hist.delete();
    m_cyc = 0; m_br = 0; m_per = 0; m_tr = 0; m_st = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [WIDTH-1:0] xv, input bit init);
    int n;
    if (init) begin
      model_clear();
      return;
    end
    if (!v) return;
    n = m_hist.size();
    if (!m_cyc) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!m_cyc && k <= n && m_hist[n-k] == xv) begin
          m_cyc = 1;
          m_per = k;
          m_tr  = (m_st - k) & ((1 << CNT_W) - 1);
        end
      end
    end else if (MON && m_hist[n-m_per] != xv) begin
      m_br = 1;
    end
    m_hist.push_back(xv);
    if (m_st != (1 << CNT_W) - 1) m_st++;
  endfunction

  task automatic step(input bit v, input logic [WIDTH-1:0] xv, input bit init);
    exp_t e;
    @(negedge clk);
    x_valid = v; x = xv; init_val_chk = init;
    model_step(v, xv, init);
    e.cyc = m_cyc; e.per = m_per; e.tr = m_tr; e.st = m_st; e.br = m_br;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all(input string tag, input bit c, input int p, input int t, input int s, input bit b);
    chk({tag, "_cyc"}, 64'(cycle_chk), 64'(c));
    chk({tag, "_per"}, 64'(period), 64'(p));
    chk({tag, "_tr"}, 64'(transient), 64'(t));
    chk({tag, "_st"}, 64'(steps), 64'(s));
    chk({tag, "_br"}, 64'(cycle_broken), 64'(b));
  endtask

  // Monitor: one expected record per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_cyc", 64'(cycle_chk), 64'(e.cyc));
        chk("sb_per", 64'(period), 64'(e.per));
        chk("sb_tr", 64'(transient), 64'(e.tr));
        chk("sb_st", 64'(steps), 64'(e.st));
        chk("sb_br", 64'(cycle_broken), 64'(e.br));
      end
    end
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Period 2 after a transient of 1
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h22, 0);
    settle();
    chk_all("p2", 1, 2, 1, 4, 0);
    step(1, 8'h33, 0); step(0, 8'h00, 0);
    settle();
    chk("p2_steps_end", 64'(steps), 64'd5);

    // Fixed point reports period 1 only
    step(0, 8'h00, 1);
    step(1, 8'h05, 0); step(1, 8'h07, 0); step(1, 8'h07, 0); step(1, 8'h07, 0); step(1, 8'h07, 0);
    step(0, 8'h00, 0);
    settle();
    chk("fix_per", 64'(period), 64'd1);
    chk("fix_tr", 64'(transient), 64'd1);

    // Period equal to DEPTH
    step(0, 8'h00, 1);
    for (int i = 0; i < 8; i++) step(1, 8'(i), 0);
    step(1, 8'h00, 0); step(0, 8'h00, 0);
    settle();
    chk("pmax_per", 64'(period), 64'd8);
    chk("pmax_tr", 64'(transient), 64'd0);

    // Period DEPTH+1 is out of reach
    step(0, 8'h00, 1);
    for (int i = 0; i < 18; i++) step(1, 8'(i % 9), 0);
    step(0, 8'h00, 0);
    settle();
    chk("p9_cyc", 64'(cycle_chk), 64'd0);

    // Gapped valid, then init beats a simultaneous sample
    step(0, 8'h00, 1);
    step(1, 8'hA0, 0); step(0, 8'hA0, 0); step(1, 8'hA0, 0); step(0, 8'h00, 0);
    settle();
    chk("gap_per", 64'(period), 64'd1);
    step(1, 8'hA0, 1); step(0, 8'h00, 0);
    settle();
    chk_all("initprio", 0, 0, 0, 0, 0);

    // Async reset between edges
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(1, 8'h03, 0);
    settle();
    #1 rst_n = 1'b0;
    #1 chk_all("arst", 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    x_valid = 1'b0;
    rst_n = 1'b1;
    step(1, 8'h01, 0); step(1, 8'h01, 0); step(0, 8'h00, 0);
    settle();
    chk("arst_per", 64'(period), 64'd1);
    chk("arst_tr", 64'(transient), 64'd0);

    // Post-lock departure from the cycle
    step(0, 8'h00, 1);
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h11, 0);
    step(1, 8'h22, 0); step(1, 8'h44, 0); step(0, 8'h00, 0);
    settle();
    chk("mon_per", 64'(period), 64'd2);
    chk("mon_br", 64'(cycle_broken), 64'(MON));

    // Random streams over a small alphabet so cycles of many periods occur
    for (int i = 0; i < 600; i++) begin
      bit v, ini;
      logic [WIDTH-1:0] xv;
      v   = ($urandom_range(0, 3) != 0);
      ini = ($urandom_range(0, 39) == 0);
      xv  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      step(v, xv, ini);
    end
    step(0, 8'h00, 0);
    settle();
    #5;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
